// File: rtl/muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// muldiv_sequencer
//
// Purpose:
//   Sequences one MULT/DIV operation at a time for the multicycle CPU. On an
//   accepted request it latches the operands and the operation type. It then
//   pulses a start strobe to the external multiplier or divider and waits for
//   that unit's done flag. When the flag arrives it commits the result into
//   the architectural HI/LO registers. While an operation is in flight it
//   stalls the control unit on new requests and on HI/LO reads. A watchdog
//   aborts a WAIT that never completes.
//
// Handshake: op_start is a level request held by the control unit until it is
//   accepted. A request is accepted only in IDLE, and it is consumed at the
//   clock edge that ends that cycle. While busy, stall tells the control unit
//   to hold its state, and the request is neither accepted nor dropped. The
//   done inputs are single-cycle strobes. Only the done strobe of the unit
//   that was started is honoured, and only in WAIT.
//
// Optional feature (macro MULDIV_DIV0_TRAP_EN):
//   defined   - a DIV with a zero divisor is refused in IDLE and raises a
//               one-cycle div0_exc pulse instead of starting the divider.
//   undefined - a zero divisor is issued like any other DIV; div0_exc stays 0.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   op_start, op_is_div         request and its type (0 MULT, 1 DIV)
//   op_a, op_b                  rs / rt operands
//   hilo_read                   MFHI/MFLO issued this cycle
//   mult_done_in, div_done_in   unit completion strobes
//   mult_hi_in, mult_lo_in      product halves
//   div_quot_in, div_rem_in     quotient / remainder
//   MultStart, DivStart         one-cycle start strobes
//   opa_q, opb_q                latched operands driven to the units
//   busy, stall                 in-flight flag, control-unit hold
//   hi, lo                      architectural HI/LO
//   div0_exc, timeout_err       registered one-cycle exception pulses
//   exception_code              010 div0, 011 timeout, otherwise 000
//   dbg_state                   current FSM state (0 IDLE, 1 START, 2 WAIT)
// ---------------------------------------------------------------------------
module muldiv_sequencer #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             op_start,
  input  logic             op_is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hilo_read,
  input  logic             mult_done_in,
  input  logic             div_done_in,
  input  logic [WIDTH-1:0] mult_hi_in,
  input  logic [WIDTH-1:0] mult_lo_in,
  input  logic [WIDTH-1:0] div_quot_in,
  input  logic [WIDTH-1:0] div_rem_in,
  output logic             MultStart,
  output logic             DivStart,
  output logic [WIDTH-1:0] opa_q,
  output logic [WIDTH-1:0] opb_q,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div0_exc,
  output logic             timeout_err,
  output logic [2:0]       exception_code,
  output logic [1:0]       dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  // The last WAIT cycle that may still see a done strobe.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_div_q, is_div_d;
  logic [WIDTH-1:0]   opa_d, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               div0_q, div0_d;
  logic               tmo_q, tmo_d;
  logic               div0_hit;
  logic               unit_done;

`ifdef MULDIV_DIV0_TRAP_EN
  assign div0_hit = op_is_div && (op_b == '0);
`else
  assign div0_hit = 1'b0;
`endif

  // Only the started unit's done strobe counts; the other one is ignored.
  assign unit_done = is_div_q ? div_done_in : mult_done_in;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      div0_q   <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      div0_q   <= div0_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    div0_d   = 1'b0;
    tmo_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_start) begin
          if (div0_hit) begin
            // Refused request: stay in IDLE, leave operands and HI/LO alone.
            div0_d = 1'b1;
          end else begin
            is_div_d = op_is_div;
            opa_d    = op_a;
            opb_d    = op_b;
            state_d  = ST_START;
          end
        end
      end
      ST_START: begin
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (unit_done) begin
          // MIPS convention: HI gets the remainder, LO the quotient.
          hi_d    = is_div_q ? div_rem_in  : mult_hi_in;
          lo_d    = is_div_q ? div_quot_in : mult_lo_in;
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tmo_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign MultStart      = (state_q == ST_START) && !is_div_q;
  assign DivStart       = (state_q == ST_START) &&  is_div_q;
  assign busy           = (state_q != ST_IDLE);
  assign stall          = busy && (op_start || hilo_read);
  assign hi             = hi_q;
  assign lo             = lo_q;
  assign div0_exc       = div0_q;
  assign timeout_err    = tmo_q;
  assign exception_code = div0_q ? 3'b010 : (tmo_q ? 3'b011 : 3'b000);
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// ---------------------------------------------------------------------------
// tb_muldiv_sequencer
//
// Bench for muldiv_sequencer (WIDTH=32, TIMEOUT=40). Inputs are driven on the
// falling clock edge and outputs are sampled there, half a cycle away from the
// active edge. Each operation pushes its expected {HI,LO} into exp_q. The
// entry is popped and compared in the cycle after the unit's done strobe.
// ---------------------------------------------------------------------------
module tb_muldiv_sequencer;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         op_start, op_is_div, hilo_read;
  logic [W-1:0] op_a, op_b;
  logic         mult_done_in, div_done_in;
  logic [W-1:0] mult_hi_in, mult_lo_in, div_quot_in, div_rem_in;
  logic         MultStart, DivStart, busy, stall, div0_exc, timeout_err;
  logic [W-1:0] opa_q, opb_q, hi, lo;
  logic [2:0]   exception_code;
  logic [1:0]   dbg_state;

  muldiv_sequencer #(.WIDTH(W), .TIMEOUT(40)) dut (
    .clk(clk), .reset(reset), .op_start(op_start), .op_is_div(op_is_div),
    .op_a(op_a), .op_b(op_b), .hilo_read(hilo_read),
    .mult_done_in(mult_done_in), .div_done_in(div_done_in),
    .mult_hi_in(mult_hi_in), .mult_lo_in(mult_lo_in),
    .div_quot_in(div_quot_in), .div_rem_in(div_rem_in),
    .MultStart(MultStart), .DivStart(DivStart),
    .opa_q(opa_q), .opb_q(opb_q), .busy(busy), .stall(stall),
    .hi(hi), .lo(lo), .div0_exc(div0_exc), .timeout_err(timeout_err),
    .exception_code(exception_code), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "time limit");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   last_hi, last_lo;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        is_div;
    logic [31:0] a, b;
    logic [31:0] u_hi, u_lo;   // unit outputs: mult hi/lo, or div rem/quot
    int          dly;          // WAIT cycles before the done strobe
    bit          spur;         // other unit's done pulses in the first WAIT cycle
    bit          rd;           // hilo_read held from START through done cycle
    bit          breq;         // op_start raised while busy (2nd WAIT cycle)
    logic [31:0] exp_hi, exp_lo;
  } vec_t;

  vec_t vecs[5];

  // ---------------- driver ----------------
  // Called at a falling edge with the DUT idle; returns at the falling edge
  // of the cycle after done, so a following call starts back-to-back.
  task automatic run_op(input logic is_div, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] u_hi, input logic [31:0] u_lo, input int dly,
                        input bit spur, input bit rd, input bit breq,
                        input logic [31:0] e_hi, input logic [31:0] e_lo);
    logic [63:0] e;
    // cycle T
    chk("idle_busy", busy, 0);
    op_start = 1'b1; op_is_div = is_div; op_a = a; op_b = b;
    exp_q.push_back({e_hi, e_lo});
    #1 chk("idle_stall", stall, 0);
    // cycle T+1: START
    @(negedge clk);
    op_start = 1'b0; op_a = $urandom; op_b = $urandom;
    chk("start_mult", MultStart, !is_div);
    chk("start_div", DivStart, is_div);
    chk("start_busy", busy, 1);
    chk("opa_latch", opa_q, a);
    chk("opb_latch", opb_q, b);
    if (rd) hilo_read = 1'b1;
    #1 chk("start_stall", stall, rd);
    // WAIT cycles without the matching done
    for (int k = 0; k < dly; k++) begin
      @(negedge clk);
      mult_done_in = 1'b0; div_done_in = 1'b0; op_start = 1'b0;
      chk("wait_busy", busy, 1);
      chk("wait_nostart", {MultStart, DivStart}, 0);
      chk("wait_hi_hold", hi, last_hi);
      if (spur && k == 0) begin
        if (is_div) begin
          mult_done_in = 1'b1; mult_hi_in = 32'hdead0001; mult_lo_in = 32'hdead0002;
        end else begin
          div_done_in = 1'b1; div_rem_in = 32'hbeef0001; div_quot_in = 32'hbeef0002;
        end
      end
      if (breq && k == 1) begin
        op_start = 1'b1; op_is_div = ~is_div; op_a = 32'h11; op_b = 32'h22;
      end
      #1 chk("wait_stall", stall, rd | (breq && k == 1));
    end
    // cycle D: done strobe, other unit's outputs carry junk
    @(negedge clk);
    mult_done_in = 1'b0; div_done_in = 1'b0; op_start = 1'b0;
    chk("done_busy", busy, 1);
    chk("done_nostart", {MultStart, DivStart}, 0);
    chk("done_lo_hold", lo, last_lo);
    if (is_div) begin
      div_done_in = 1'b1; div_rem_in = u_hi; div_quot_in = u_lo;
      mult_hi_in = 32'hcafe0001; mult_lo_in = 32'hcafe0002;
    end else begin
      mult_done_in = 1'b1; mult_hi_in = u_hi; mult_lo_in = u_lo;
      div_rem_in = 32'hface0001; div_quot_in = 32'hface0002;
    end
    #1 chk("done_stall", stall, rd);
    // cycle D+1: results visible, idle again
    @(negedge clk);
    mult_done_in = 1'b0; div_done_in = 1'b0;
    chk("post_busy", busy, 0);
    chk("post_nostart", {MultStart, DivStart}, 0);
    if (exp_q.size() == 0) begin
      chk("sb_underflow", 1, 0);
    end else begin
      e = exp_q.pop_front();
      chk("hi_result", hi, e[63:32]);
      chk("lo_result", lo, e[31:0]);
      last_hi = e[63:32];
      last_lo = e[31:0];
    end
    #1 chk("post_stall", stall, 0);
    hilo_read = 1'b0;
  endtask

  // ---------------- test ----------------
  initial begin
    logic        r_div;
    logic [31:0] ra, rb;
    int          rdly;

    vecs[0] = '{is_div:1'b0, a:32'd7,   b:32'd6,  u_hi:32'd0, u_lo:32'd42, dly:4,
                spur:1'b0, rd:1'b0, breq:1'b0, exp_hi:32'd0, exp_lo:32'd42};
    vecs[1] = '{is_div:1'b1, a:32'd17,  b:32'd5,  u_hi:32'd2, u_lo:32'd3,  dly:3,
                spur:1'b1, rd:1'b0, breq:1'b0, exp_hi:32'd2, exp_lo:32'd3};
    vecs[2] = '{is_div:1'b0, a:32'hffffffff, b:32'd2, u_hi:32'd1, u_lo:32'hfffffffe, dly:3,
                spur:1'b0, rd:1'b1, breq:1'b1, exp_hi:32'd1, exp_lo:32'hfffffffe};
    vecs[3] = '{is_div:1'b1, a:32'd100, b:32'd7,  u_hi:32'd2, u_lo:32'd14, dly:0,
                spur:1'b0, rd:1'b0, breq:1'b0, exp_hi:32'd2, exp_lo:32'd14};
    vecs[4] = '{is_div:1'b0, a:32'h1234, b:32'h10, u_hi:32'd0, u_lo:32'h12340, dly:6,
                spur:1'b1, rd:1'b1, breq:1'b1, exp_hi:32'd0, exp_lo:32'h12340};

    reset = 1'b1; op_start = 1'b0; op_is_div = 1'b0; op_a = '0; op_b = '0;
    hilo_read = 1'b0; mult_done_in = 1'b0; div_done_in = 1'b0;
    mult_hi_in = '0; mult_lo_in = '0; div_quot_in = '0; div_rem_in = '0;
    last_hi = '0; last_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // reset state
    chk("rst_state", dbg_state, 0);
    chk("rst_busy", busy, 0);
    chk("rst_stall", stall, 0);
    chk("rst_starts", {MultStart, DivStart}, 0);
    chk("rst_hilo", {hi, lo}, 0);
    chk("rst_ops", {opa_q, opb_q}, 0);
    chk("rst_exc", {div0_exc, timeout_err, exception_code}, 0);

    // table vectors, back-to-back
    for (int i = 0; i < 5; i++)
      run_op(vecs[i].is_div, vecs[i].a, vecs[i].b, vecs[i].u_hi, vecs[i].u_lo,
             vecs[i].dly, vecs[i].spur, vecs[i].rd, vecs[i].breq,
             vecs[i].exp_hi, vecs[i].exp_lo);

    // random operations; the bench acts as the external unit
    for (int i = 0; i < 6; i++) begin
      r_div = 1'($urandom_range(0, 1));
      ra    = $urandom_range(1, 5000);
      rb    = $urandom_range(1, 60);
      rdly  = $urandom_range(0, 8);
      if (r_div)
        run_op(1'b1, ra, rb, ra % rb, ra / rb, rdly, 1'b1, 1'b0, 1'b0, ra % rb, ra / rb);
      else
        run_op(1'b0, ra, rb, 32'd0, ra * rb, rdly, 1'b0, 1'b1, 1'b0, 32'd0, ra * rb);
    end

    // divide by zero
`ifdef MULDIV_DIV0_TRAP_EN
    op_start = 1'b1; op_is_div = 1'b1; op_a = 32'd55; op_b = 32'd0;
    @(negedge clk);
    op_start = 1'b0;
    chk("div0_nostart", DivStart, 0);
    chk("div0_busy", busy, 0);
    chk("div0_pulse", div0_exc, 1);
    chk("div0_code", exception_code, 3'b010);
    @(negedge clk);
    chk("div0_pulse_end", div0_exc, 0);
    chk("div0_code_end", exception_code, 0);
    chk("div0_hilo", {hi, lo}, {last_hi, last_lo});
`else
    run_op(1'b1, 32'd55, 32'd0, 32'd55, 32'hffffffff, 1, 1'b0, 1'b0, 1'b0,
           32'd55, 32'hffffffff);
    chk("div0_noexc", {div0_exc, exception_code}, 0);
`endif

    // watchdog timeout: no done ever
    op_start = 1'b1; op_is_div = 1'b0; op_a = 32'd3; op_b = 32'd9;
    @(negedge clk);   // T+1
    op_start = 1'b0;
    for (int c = 2; c <= 43; c++) begin
      @(negedge clk);
      if (c < 42) begin
        chk("tmo_early", timeout_err, 0);
        chk("tmo_busy", busy, 1);
      end else if (c == 42) begin
        chk("tmo_pulse", timeout_err, 1);
        chk("tmo_code", exception_code, 3'b011);
        chk("tmo_idle", busy, 0);
        chk("tmo_hilo", {hi, lo}, {last_hi, last_lo});
      end else begin
        chk("tmo_pulse_end", timeout_err, 0);
        chk("tmo_code_end", exception_code, 0);
        chk("tmo_still_idle", busy, 0);
      end
    end

    // reset while in WAIT, then a late done
    op_start = 1'b1; op_is_div = 1'b0; op_a = 32'd5; op_b = 32'd5;
    @(negedge clk);
    op_start = 1'b0;
    @(negedge clk);
    chk("rw_in_wait", dbg_state, 2);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    mult_done_in = 1'b1; mult_hi_in = 32'habab; mult_lo_in = 32'hcdcd;
    chk("rw_state", dbg_state, 0);
    chk("rw_hilo_rst", {hi, lo}, 0);
    @(negedge clk);
    mult_done_in = 1'b0;
    chk("rw_late_done_state", dbg_state, 0);
    chk("rw_late_done_hilo", {hi, lo}, 0);
    chk("rw_nostart", {MultStart, DivStart}, 0);

    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
